// File: rtl/key_encoder8_3.sv
// rtl/key_encoder8_3.sv - synchronise, debounce and priority-encode 8 active-low keys into a 3-bit code
module key_encoder8_3 #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn_n,
    output logic [2:0] code,
    output logic       valid,
    output logic       pressed,
    output logic       multi
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    logic [7:0]       s1_q, s2_q, last_q, stable_q;
    logic [CNT_W-1:0] cnt_q;
    state_t           state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             pressed_q, pressed_d;
    logic             multi_q, multi_d;

    logic [7:0]       act;
    logic [2:0]       prio;
    logic             act_multi;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 8'hFF;
            s2_q      <= 8'hFF;
            last_q    <= 8'hFF;
            stable_q  <= 8'hFF;
            cnt_q     <= '0;
            state_q   <= IDLE;
            code_q    <= 3'd0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            s1_q <= btn_n;
            s2_q <= s1_q;
            // Any bit moving restarts the window for the whole vector; the counter saturates.
            if (s2_q != last_q) begin
                last_q <= s2_q;
                cnt_q  <= '0;
            end else if (cnt_q == CNT_MAX) begin
                stable_q <= last_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
            multi_q   <= multi_d;
        end
    end

    assign act = ~stable_q;

    always_comb begin
        prio = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) begin
                prio = 3'(i);
            end
        end
    end

    // More than one bit set iff clearing the lowest set bit leaves something behind.
    assign act_multi = (act & (act - 8'd1)) != 8'd0;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        pressed_d = pressed_q;
        multi_d   = multi_q;
        case (state_q)
            IDLE: begin
                if (act != 8'd0) begin
                    code_d    = prio;
                    multi_d   = act_multi;
                    valid_d   = 1'b1;
                    pressed_d = 1'b1;
                    state_d   = HELD;
                end
            end
            HELD: begin
                if (act == 8'd0) begin
                    pressed_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pressed = pressed_q;
    assign multi   = multi_q;

endmodule
